// File: rtl/rx_rs_gearbox_pkg.sv
// Shared XGMII control characters, link-fault encodings and state types
// for the receive reconciliation front end.
package rx_rs_gearbox_pkg;

    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SEQ      = 8'h9C;
    localparam logic [7:0] LF_LOCAL       = 8'h01;
    localparam logic [7:0] LF_REMOTE      = 8'h02;

    typedef enum logic [1:0] {
        OK,
        LOCAL,
        REMOTE
    } lf_state_t;

    typedef enum logic {
        FT_LOCAL,
        FT_REMOTE
    } lf_type_t;

endpackage

// File: rtl/rx_link_fault_sm.sv
// Link-fault sequence state machine: qualifies runs of same-type fault
// columns and holds the resulting fault state until a quiet window elapses.
module rx_link_fault_sm
    import rx_rs_gearbox_pkg::*;
#(
    parameter int LF_COUNT  = 4,
    parameter int LF_WINDOW = 128
) (
    input  logic     rxclk_2x,
    input  logic     reset,
    input  logic     fault_valid,
    input  lf_type_t fault_type,
    output logic     local_fault,
    output logic     remote_fault
);

    localparam int SEQ_W = $clog2(LF_COUNT + 1);
    localparam int COL_W = $clog2(LF_WINDOW + 1);
    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(LF_COUNT);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(LF_WINDOW);

    lf_state_t        state, state_next;
    lf_type_t         last_type, last_type_next;
    logic [SEQ_W-1:0] seq_cnt, seq_next;
    logic [COL_W-1:0] col_cnt, col_next;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge rxclk_2x or negedge reset) begin
        if (!reset) begin
            state     <= OK;
            last_type <= FT_LOCAL;
            seq_cnt   <= '0;
            col_cnt   <= '0;
        end else begin
            state     <= state_next;
            last_type <= last_type_next;
            seq_cnt   <= seq_next;
            col_cnt   <= col_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state;
        last_type_next = last_type;
        seq_next       = seq_cnt;
        col_next       = col_cnt;

        if (fault_valid) begin
            if (fault_type == last_type && col_cnt < COL_MAX) begin
                if (seq_cnt != SEQ_MAX) seq_next = seq_cnt + 1'b1;
            end else begin
                seq_next = SEQ_W'(1);
            end
            last_type_next = fault_type;
            col_next       = '0;
            // A type change in a fault state holds until the new type qualifies.
            if (seq_next == SEQ_MAX)
                state_next = (fault_type == FT_LOCAL) ? LOCAL : REMOTE;
        end else begin
            if (col_cnt != COL_MAX) col_next = col_cnt + 1'b1;
            if (col_next == COL_MAX) begin
                state_next = OK;
                seq_next   = '0;
            end
        end
    end

    assign local_fault  = (state == LOCAL);
    assign remote_fault = (state == REMOTE);

endmodule

// File: rtl/rx_rs_gearbox.sv
// Receive reconciliation front end: classifies XGMII columns, assembles
// RATIO columns per output word with Start aligned to slot 0, tracks link fault.
module rx_rs_gearbox
    import rx_rs_gearbox_pkg::*;
#(
    parameter int RATIO     = 2,
    parameter int LF_COUNT  = 4,
    parameter int LF_WINDOW = 128
) (
    input  logic                  rxclk_2x,
    input  logic                  reset,
    input  logic [31:0]           rxd,
    input  logic [3:0]            rxc,
    output logic [32*RATIO-1:0]   rxd_out,
    output logic [4*RATIO-1:0]    rxc_out,
    output logic                  out_valid,
    output logic                  local_fault,
    output logic                  remote_fault
);

    logic     is_start;
    logic     is_fault;
    lf_type_t fault_type;

    always_comb begin
        is_start = (rxd[7:0] == XGMII_START) && rxc[0] &&
                   (rxd[15:8] == XGMII_PREAMBLE) && !rxc[1];
        is_fault = (rxc == 4'b0001) && (rxd[7:0] == XGMII_SEQ) &&
                   (rxd[23:8] == 16'h0000) &&
                   (rxd[31:24] == LF_LOCAL || rxd[31:24] == LF_REMOTE);
        fault_type = (rxd[31:24] == LF_REMOTE) ? FT_REMOTE : FT_LOCAL;
    end

    generate
        if (RATIO == 1) begin : g_pass
            always_ff @(posedge rxclk_2x or negedge reset) begin
                if (!reset) begin
                    rxd_out   <= '0;
                    rxc_out   <= '0;
                    out_valid <= 1'b0;
                end else begin
                    rxd_out   <= rxd;
                    rxc_out   <= rxc;
                    out_valid <= 1'b1;
                end
            end
        end else begin : g_gear
            localparam int PH_W = $clog2(RATIO);
            localparam logic [PH_W-1:0] LAST = PH_W'(RATIO - 1);

            logic [PH_W-1:0]          ph;
            logic [PH_W-1:0]          wr_slot;
            logic                     last_slot;
            logic [32*(RATIO-1)-1:0]  dbuf;
            logic [4*(RATIO-1)-1:0]   cbuf;

            // A Start restarts the word at slot 0, dropping any partial word.
            assign wr_slot   = is_start ? '0 : ph;
            assign last_slot = (wr_slot == LAST);

            always_ff @(posedge rxclk_2x or negedge reset) begin
                if (!reset) begin
                    ph        <= '0;
                    rxd_out   <= '0;
                    rxc_out   <= '0;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= last_slot;
                    ph        <= last_slot ? '0 : wr_slot + 1'b1;
                    if (last_slot) begin
                        rxd_out <= {rxd, dbuf};
                        rxc_out <= {rxc, cbuf};
                    end
                end
            end

            // NOTE: the slot buffer is deliberately not reset; ph restarts at 0,
            // so every slot is rewritten before it can reach the output.
            always_ff @(posedge rxclk_2x) begin
                if (!last_slot) begin
                    dbuf[32*wr_slot +: 32] <= rxd;
                    cbuf[4*wr_slot +: 4]   <= rxc;
                end
            end
        end
    endgenerate

    rx_link_fault_sm #(
        .LF_COUNT  (LF_COUNT),
        .LF_WINDOW (LF_WINDOW)
    ) u_link_fault (
        .rxclk_2x     (rxclk_2x),
        .reset        (reset),
        .fault_valid  (is_fault),
        .fault_type   (fault_type),
        .local_fault  (local_fault),
        .remote_fault (remote_fault)
    );

endmodule

// File: tb/tb_rx_rs_gearbox.sv
// Directed bench for rx_rs_gearbox: gearbox alignment at RATIO 1/2/4,
// link-fault qualification, clearing window and asynchronous reset.
module tb_rx_rs_gearbox;

    localparam logic [31:0] IDLE_D  = 32'h0707_0707;
    localparam logic [3:0]  IDLE_C  = 4'hF;
    localparam logic [31:0] START_D = 32'h5555_55FB;
    localparam logic [31:0] LOC_D   = 32'h0100_009C;
    localparam logic [31:0] REM_D   = 32'h0200_009C;

    logic        rxclk_2x = 1'b0;
    logic        reset;
    logic [31:0] rxd;
    logic [3:0]  rxc;

    logic [63:0]  d2_rxd;  logic [7:0]  d2_rxc;  logic d2_v, d2_lf, d2_rf;
    logic [127:0] d4_rxd;  logic [15:0] d4_rxc;  logic d4_v, d4_lf, d4_rf;
    logic [31:0]  d1_rxd;  logic [3:0]  d1_rxc;  logic d1_v, d1_lf, d1_rf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 rxclk_2x = ~rxclk_2x;

    rx_rs_gearbox dut (
        .rxclk_2x(rxclk_2x), .reset(reset), .rxd(rxd), .rxc(rxc),
        .rxd_out(d2_rxd), .rxc_out(d2_rxc), .out_valid(d2_v),
        .local_fault(d2_lf), .remote_fault(d2_rf)
    );

    rx_rs_gearbox #(.RATIO(4)) dut4 (
        .rxclk_2x(rxclk_2x), .reset(reset), .rxd(rxd), .rxc(rxc),
        .rxd_out(d4_rxd), .rxc_out(d4_rxc), .out_valid(d4_v),
        .local_fault(d4_lf), .remote_fault(d4_rf)
    );

    rx_rs_gearbox #(.RATIO(1)) dut1 (
        .rxclk_2x(rxclk_2x), .reset(reset), .rxd(rxd), .rxc(rxc),
        .rxd_out(d1_rxd), .rxc_out(d1_rxc), .out_valid(d1_v),
        .local_fault(d1_lf), .remote_fault(d1_rf)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one column, let the next rising edge sample it, settle 1 time unit.
    task automatic send(input logic [31:0] d, input logic [3:0] c);
        rxd = d;
        rxc = c;
        @(posedge rxclk_2x);
        #1;
    endtask

    function automatic logic [31:0] data_col(input int i);
        return 32'hDA7A_0000 | 32'(i);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic saw;
        reset = 1'b0;
        rxd   = IDLE_D;
        rxc   = IDLE_C;
        #1;
        check("rst_rxd_out", d2_rxd, 64'h0);
        check("rst_rxc_out", d2_rxc, 8'h0);
        check("rst_valid",   {d4_v, d2_v, d1_v}, 3'b000);
        check("rst_faults",  {d2_lf, d2_rf}, 2'b00);
        repeat (2) @(posedge rxclk_2x);
        @(negedge rxclk_2x);
        reset = 1'b1;

        // Idle goes to slot 0, then a Start realigns and discards it.
        send(IDLE_D, IDLE_C);
        check("a_idle_valid", d2_v, 1'b0);
        send(START_D, 4'b0001);
        check("a_start_valid", d2_v, 1'b0);
        send(data_col(1), 4'h0);
        check("a_word_valid", d2_v, 1'b1);
        check("a_start_lane0", d2_rxd[7:0], 8'hFB);
        check("a_start_ctl0", d2_rxc[0], 1'b1);
        check("a_word", d2_rxd, {data_col(1), START_D});
        check("a_word_ctl", d2_rxc, 8'h01);

        // Continue to 10 data columns after the Start.
        for (int i = 2; i <= 10; i++) begin
            send(data_col(i), 4'h0);
            check($sformatf("b_r4_valid_%0d", i), d4_v, (i == 3 || i == 7));
            check($sformatf("b_r2_valid_%0d", i), d2_v, (i % 2 == 1));
            if (i == 3) begin
                check("b_r4_word0", d4_rxd, {data_col(3), data_col(2), data_col(1), START_D});
                check("b_r4_ctl0", d4_rxc, 16'h0001);
            end
            if (i == 7)
                check("b_r4_word1", d4_rxd, {data_col(7), data_col(6), data_col(5), data_col(4)});
        end
        check("b_r1_valid", d1_v, 1'b1);
        check("b_r1_word", {d1_rxc, d1_rxd}, {4'h0, data_col(10)});

        // Local faults every 3rd column; fault columns pass through unmodified.
        for (int k = 1; k <= 4; k++) begin
            send(LOC_D, 4'b0001);
            if (k == 1) check("c_fault_passthru", {d2_rxc, d2_rxd}, {8'h10, LOC_D, data_col(10)});
            check($sformatf("c_local_%0d", k), d2_lf, (k == 4));
            check($sformatf("c_remote_%0d", k), d2_rf, 1'b0);
            if (k < 4) begin
                send(IDLE_D, IDLE_C);
                send(IDLE_D, IDLE_C);
            end
        end
        check("c_r4_local", d4_lf, 1'b1);
        repeat (127) send(IDLE_D, IDLE_C);
        check("c_local_hold_127", d2_lf, 1'b1);
        send(IDLE_D, IDLE_C);
        check("c_local_clear_128", d2_lf, 1'b0);

        // Three local then four remote, then a switch back to local.
        for (int k = 0; k < 3; k++) begin
            send(LOC_D, 4'b0001);
            check($sformatf("d_loc_%0d", k), {d2_lf, d2_rf}, 2'b00);
        end
        for (int k = 0; k < 4; k++) begin
            send(REM_D, 4'b0001);
            check($sformatf("d_rem_%0d", k), {d2_lf, d2_rf}, {1'b0, (k == 3)});
        end
        for (int k = 0; k < 4; k++) begin
            send(LOC_D, 4'b0001);
            check($sformatf("d_switch_%0d", k), {d2_lf, d2_rf}, (k == 3) ? 2'b10 : 2'b01);
        end
        repeat (128) send(IDLE_D, IDLE_C);
        check("d_cleared", {d2_lf, d2_rf}, 2'b00);

        // Faults 130 columns apart never qualify.
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send(LOC_D, 4'b0001);
            saw = saw | d2_lf;
            repeat (129) send(IDLE_D, IDLE_C);
        end
        check("e_never_local", saw, 1'b0);

        // Faults 128 columns apart are still within the window.
        for (int k = 1; k <= 4; k++) begin
            send(LOC_D, 4'b0001);
            check($sformatf("e_edge_local_%0d", k), d2_lf, (k == 4));
            if (k < 4) repeat (127) send(IDLE_D, IDLE_C);
        end

        // Reset mid-word while local_fault is set.
        send(START_D, 4'b0001);
        check("f_pre_local", d2_lf, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("f_rst_local", d2_lf, 1'b0);
        check("f_rst_outs", {d2_v, d2_rxc, d2_rxd}, 73'h0);
        check("f_rst_r4", {d4_v, d4_rxd}, 129'h0);
        @(posedge rxclk_2x);
        @(negedge rxclk_2x);
        reset = 1'b1;
        send(data_col(21), 4'h0);
        check("f_first_valid", d2_v, 1'b0);
        send(data_col(22), 4'h0);
        check("f_r2_word", {d2_v, d2_rxd}, {1'b1, data_col(22), data_col(21)});
        send(data_col(23), 4'h0);
        send(data_col(24), 4'h0);
        check("f_r4_word", {d4_v, d4_rxd},
              {1'b1, data_col(24), data_col(23), data_col(22), data_col(21)});
        check("f_post_faults", {d2_lf, d2_rf}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
